// File: rtl/chunk_stream_mover.sv
// chunk_stream_mover: AXI-Stream <-> LBM BRAM chunk mover (load, hand to solver, unload).
// Optional CHUNK_CHECKSUM_EN adds a running lane-sum of every loaded beat on load_checksum.
module chunk_stream_mover #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int NDIR   = 9
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_areset,
    input  logic                     start,
    input  logic [ADDR_W:0]          cfg_chunk_len,
    input  logic                     compute_done,
    input  logic [NDIR*DATA_W-1:0]   s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [NDIR*DATA_W-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     chunk_transfer_ready,
    output logic                     chunk_compute_ready,
    output logic [ADDR_W-1:0]        DDR_addr,
    output logic                     cache_wen,
    output logic [NDIR*DATA_W-1:0]   cache_data_in,
    input  logic [NDIR*DATA_W-1:0]   cache_data_out,
    output logic                     busy,
    output logic                     err_tlast,
    output logic [DATA_W-1:0]        load_checksum
);
    localparam int BW = NDIR * DATA_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [BW-1:0]   fifo_q [2];
    logic [BW-1:0]   fifo_d [2];
    logic [1:0]      last_q, last_d, cnt_q, cnt_d;
    logic            ptr_q, ptr_d, infl_q, infl_d, infl_last_q, infl_last_d, err_q, err_d;
    logic            go, wr, last_beat, pop, issue;

    always_comb begin
        go = state_q == IDLE && start && cfg_chunk_len != '0 && cfg_chunk_len <= MAX_LEN;
        wr = state_q == LOAD && s_axis_tvalid;
        last_beat = wr_cnt_q == len_q - ONE;
        m_axis_tvalid = cnt_q != 2'd0;
        m_axis_tdata = fifo_q[ptr_q];
        m_axis_tlast = m_axis_tvalid && last_q[ptr_q];
        pop = m_axis_tvalid && m_axis_tready;
        // Skid FIFO never overflows: reads in flight are counted against the 2 slots.
        issue = state_q == UNLOAD && rd_cnt_q < len_q &&
                ({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});
        s_axis_tready = state_q == LOAD;
        cache_wen = wr;
        cache_data_in = state_q == LOAD ? s_axis_tdata : '0;
        DDR_addr = state_q == LOAD ? wr_cnt_q[ADDR_W-1:0] : issue ? rd_cnt_q[ADDR_W-1:0] : '0;
        chunk_transfer_ready = state_q == LOAD || state_q == UNLOAD;
        chunk_compute_ready = state_q == COMPUTE;
        busy = state_q != IDLE;
        err_tlast = err_q;
    end

    always_comb begin
        state_d = state_q;
        len_d = len_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = issue ? rd_cnt_q + ONE : rd_cnt_q;
        err_d = err_q;
        fifo_d = fifo_q;
        last_d = last_q;
        infl_d = issue;
        infl_last_d = rd_cnt_q == len_q - ONE;
        ptr_d = ptr_q ^ pop;
        cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
        if (infl_q) begin
            fifo_d[ptr_q ^ cnt_q[0]] = cache_data_out;
            last_d[ptr_q ^ cnt_q[0]] = infl_last_q;
        end
        case (state_q)
            IDLE: if (go) begin
                state_d = LOAD;
                len_d = cfg_chunk_len;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                err_d = 1'b0;
            end
            LOAD: if (wr) begin
                wr_cnt_d = wr_cnt_q + ONE;
                err_d = err_q | (s_axis_tlast != last_beat);
                state_d = last_beat ? COMPUTE : LOAD;
            end
            COMPUTE: state_d = compute_done ? UNLOAD : COMPUTE;
            UNLOAD: state_d = pop && m_axis_tlast ? IDLE : UNLOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state_q <= IDLE;
            len_q <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q <= 1'b0;
            fifo_q <= '{default: '0};
            last_q <= '0;
            cnt_q <= '0;
            ptr_q <= 1'b0;
            infl_q <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q <= err_d;
            fifo_q <= fifo_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            infl_q <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

`ifdef CHUNK_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d, beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < NDIR; k++) beat_sum = beat_sum + s_axis_tdata[k*DATA_W +: DATA_W];
        sum_d = go ? '0 : wr ? sum_q + beat_sum : sum_q;
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) sum_q <= '0;
        else sum_q <= sum_d;
    end

    assign load_checksum = sum_q;
`else
    assign load_checksum = '0;
`endif
endmodule
